// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM encoding, frame layout
// and the keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;
    // The start bit is driven directly, so only the remaining bits are shifted out.
    localparam int SHIFT_LEN = FRAME_LEN - 1;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic logic [SHIFT_LEN-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes raw PS2C/PS2D pins into clk and flags falling edges of the device clock.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] c_sr;
    logic [SYNC_STAGES-1:0] d_sr;
    logic                   clk_prev;

    // Flops reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sr     <= '1;
            d_sr     <= '1;
            clk_prev <= 1'b1;
        end else begin
            c_sr[0] <= ps2c_in;
            d_sr[0] <= ps2d_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                c_sr[i] <= c_sr[i-1];
                d_sr[i] <= d_sr[i-1];
            end
            clk_prev <= c_sr[SYNC_STAGES-1];
        end
    end

    assign clk_s = c_sr[SYNC_STAGES-1];
    assign dat_s = d_sr[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter; requests open-drain pulls on PS2C/PS2D.
//
//  state        | meaning
//  -------------+----------------------------------------------------------
//  ST_IDLE      | lines released, waiting for start
//  ST_INHIBIT   | PS2C held low, then start bit on PS2D, then PS2C released
//  ST_SEND      | data/parity/stop driven after each device clock fall
//  ST_ACK       | sample device ACK on the 11th fall
//  ST_WAIT_IDLE | wait for both lines high before reporting done
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_low,
    output logic       ps2d_low,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W = $clog2(SHIFT_LEN);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_SAT  = INH_W'(INHIBIT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_SAT   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SHIFT_LEN - 1);

    logic                 clk_s;
    logic                 dat_s;
    logic                 fall;
    ps2_state_t           state;
    logic [SHIFT_LEN-1:0] frame;
    logic [BIT_W-1:0]     bitcnt;
    logic [INH_W-1:0]     inh_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic                 timed;
    logic                 bus_idle;
    logic                 to_hit;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .fall   (fall)
    );

    assign timed    = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    assign bus_idle = clk_s & dat_s;
    // A completing WAIT_IDLE wins over a timeout landing in the same cycle.
    assign to_hit   = timed && !fall && (to_cnt == TO_LAST)
                      && !((state == ST_WAIT_IDLE) && bus_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            frame    <= '0;
            bitcnt   <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            if (timed) begin
                if (fall)
                    to_cnt <= '0;
                else if (to_cnt != TO_SAT)
                    to_cnt <= to_cnt + 1'b1;
            end

            if (to_hit) begin
                ps2c_low <= 1'b0;
                ps2d_low <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            frame    <= build_frame(din);
                            inh_cnt  <= '0;
                            busy     <= 1'b1;
                            ps2c_low <= 1'b1;
                            state    <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (inh_cnt == INH_SAT) begin
                            ps2c_low <= 1'b0;
                            bitcnt   <= '0;
                            to_cnt   <= '0;
                            state    <= ST_SEND;
                        end else begin
                            if (inh_cnt == INH_LAST)
                                ps2d_low <= 1'b1;
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (fall) begin
                            ps2d_low <= ~frame[bitcnt];
                            if (bitcnt == BIT_LAST) begin
                                to_cnt <= '0;
                                state  <= ST_ACK;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (fall) begin
                            if (!dat_s) begin
                                to_cnt <= '0;
                                state  <= ST_WAIT_IDLE;
                            end else begin
                                ps2c_low <= 1'b0;
                                ps2d_low <= 1'b0;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (bus_idle) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        ps2c_low <= 1'b0;
                        ps2d_low <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on an open-drain bus.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 400;
    localparam int HALF = 30;

    localparam int DEV_ACK    = 0;
    localparam int DEV_NOACK  = 1;
    localparam int DEV_SILENT = 2;
    localparam int DEV_RESET  = 3;

    localparam int RES_DONE  = 0;
    localparam int RES_ERROR = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_low;
    logic       ps2d_low;
    logic       busy;
    logic       done;
    logic       error;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_res_q[$];
    logic [9:0] exp_frame_q[$];
    logic [9:0] obs_frame_q[$];
    int         mon_res;
    logic [9:0] mon_obs;
    logic [9:0] mon_exp;

    assign ps2c_in = ~ps2c_low & dev_clk;
    assign ps2d_in = ~ps2d_low & dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_low(ps2c_low),
        .ps2d_low(ps2d_low),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Result / frame monitor: pops the scoreboard whenever the DUT or bus presents something.
    always @(negedge clk) begin
        if (!rst && done && error) begin
            check("done_error_exclusive", 1, 0);
        end else if (!rst && (done || error)) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_pulse", done ? 1 : 2, 0);
            end else begin
                mon_res = exp_res_q.pop_front();
                check("result_kind", done ? RES_DONE : RES_ERROR, mon_res);
                check("busy_at_pulse", int'(busy), 0);
            end
        end
        if (obs_frame_q.size() > 0) begin
            mon_obs = obs_frame_q.pop_front();
            if (exp_frame_q.size() == 0) begin
                check("unexpected_frame", int'(mon_obs), -1);
            end else begin
                mon_exp = exp_frame_q.pop_front();
                check("frame_bits", int'(mon_obs), int'(mon_exp));
            end
        end
    end

    task automatic send_start(input logic [7:0] data);
        @(negedge clk);
        start = 1'b1;
        din   = data;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("busy_released", int'(busy), 0);
    endtask

    // Device side: waits for request-to-send, then clocks the frame in and optionally ACKs.
    task automatic device(input int mode);
        int         k = 0;
        logic [9:0] bits = '0;
        while (!(ps2d_low && !ps2c_low) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            check("request_seen", 0, 1);
            return;
        end
        if (mode == DEV_SILENT)
            return;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            repeat (HALF / 2) @(negedge clk);
            if (i == 11 && mode == DEV_ACK)
                dev_dat = 1'b0;
            repeat (HALF - HALF / 2) @(negedge clk);
            dev_clk = 1'b0;
            if (mode == DEV_RESET && i == 5) begin
                repeat (10) @(negedge clk);
                check("bit4_data_driven", int'(ps2d_low), 1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("rst_ps2c_low", int'(ps2c_low), 0);
                check("rst_ps2d_low", int'(ps2d_low), 0);
                check("rst_busy", int'(busy), 0);
                @(negedge clk);
                rst     = 1'b0;
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                repeat (100) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            if (i <= 10)
                bits[i-1] = ps2d_in;
            dev_clk = 1'b1;
        end
        obs_frame_q.push_back(bits);
        repeat (HALF) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;

        repeat (3) @(negedge clk);
        check("reset_ps2c_low", int'(ps2c_low), 0);
        check("reset_ps2d_low", int'(ps2d_low), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: data 1,0,1,1,0,1,1,1 then parity 1, stop 1
        exp_frame_q.push_back(10'b11_1110_1101);
        exp_res_q.push_back(RES_DONE);
        send_start(8'hED);
        check("busy_after_start", int'(busy), 1);
        n = 0;
        while (ps2c_low && !ps2d_low && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", n, INH);
        check("start_bit_with_clk_low", int'(ps2c_low && ps2d_low), 1);
        device(DEV_ACK);
        wait_not_busy();

        // 0x00 -> parity 1 ; 0x01 -> parity 0
        exp_frame_q.push_back(10'h300);
        exp_res_q.push_back(RES_DONE);
        send_start(8'h00);
        device(DEV_ACK);
        wait_not_busy();

        exp_frame_q.push_back(10'h201);
        exp_res_q.push_back(RES_DONE);
        send_start(8'h01);
        device(DEV_ACK);
        wait_not_busy();

        // Device never clocks: error 400 cycles after PS2C release
        exp_res_q.push_back(RES_ERROR);
        send_start(8'hED);
        device(DEV_SILENT);
        n = 0;
        while (!error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_ps2c_low", int'(ps2c_low), 0);
        check("timeout_ps2d_low", int'(ps2d_low), 0);
        wait_not_busy();
        repeat (20) @(negedge clk);

        // Missing ACK
        exp_frame_q.push_back(10'h3FF);
        exp_res_q.push_back(RES_ERROR);
        send_start(8'hFF);
        device(DEV_NOACK);
        wait_not_busy();
        repeat (20) @(negedge clk);

        // Reset during bit 4 of 0xED (bit 4 is 0, so PS2D is being pulled)
        send_start(8'hED);
        device(DEV_RESET);

        exp_frame_q.push_back(10'h3FF);
        exp_res_q.push_back(RES_DONE);
        send_start(ps2_pkg::CMD_RESET);
        device(DEV_ACK);
        wait_not_busy();

        // Second start during INHIBIT must not disturb the frame in flight
        exp_frame_q.push_back(10'h201);
        exp_res_q.push_back(RES_DONE);
        send_start(8'h01);
        repeat (5) @(negedge clk);
        send_start(8'hAA);
        device(DEV_ACK);
        wait_not_busy();
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (ps2c_low || ps2d_low || busy)
                seen = 1'b1;
        end
        check("no_second_request", int'(seen), 0);

        repeat (10) @(negedge clk);
        check("pending_results", exp_res_q.size(), 0);
        check("pending_frames", exp_frame_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
